// File: rtl/serial_word_collector.sv
// Collects an LSB-first serial bit stream into WIDTH-bit words and presents
// each word through a one-deep valid/ready holding buffer with framing pulse.
module serial_word_collector #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             frame_done,
    output logic             overrun
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t       state;
    buf_state_t       state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] new_word;
    logic             complete;
    logic             load;
    logic             drop;

    assign new_word = {bit_in, shreg[WIDTH-1:1]};
    assign complete = bit_valid && (cnt == LAST);

    // NOTE: every output of an always_comb gets a default first so that no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        unique case (state)
            EMPTY: begin
                if (complete) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (complete) begin
                    // A same-edge handshake frees the slot for the new word.
                    if (word_ready) load = 1'b1;
                    else            drop = 1'b1;
                end else if (word_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            shreg      <= '0;
            cnt        <= '0;
            word_out   <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= complete;
            if (bit_valid) begin
                shreg <= new_word;
                cnt   <= complete ? '0 : cnt + CW'(1);
            end
            if (load) word_out <= new_word;
            if (drop) overrun  <= 1'b1;
        end
    end

    assign word_valid = (state == FULL);

endmodule

// File: tb/tb_serial_word_collector.sv
// Randomized and directed bench: a queue-based reference model predicts words,
// and a negedge monitor pops the scoreboard on every completed handshake.
module tb_serial_word_collector;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_in;
    logic             bit_valid;
    logic             word_ready;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             frame_done;
    logic             overrun;

    serial_word_collector #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bits since the last word boundary, and words the
    // consumer has yet to take.
    bit               bits_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_last;
    bit               exp_full;
    bit               exp_frame;
    bit               exp_overrun;
    bit               started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input bit b, input bit rdy);
        bit     done;
        longint acc;
        if (r) begin
            bits_q.delete();
            exp_q.delete();
            exp_last    = '0;
            exp_full    = 1'b0;
            exp_frame   = 1'b0;
            exp_overrun = 1'b0;
            return;
        end
        done = 1'b0;
        acc  = 0;
        if (v) begin
            bits_q.push_back(b);
            if (bits_q.size() == WIDTH) begin
                for (int i = 0; i < WIDTH; i++) acc += longint'(bits_q[i]) * (longint'(1) << i);
                bits_q.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!exp_full || rdy) begin
                exp_q.push_back(WIDTH'(acc));
                exp_last = WIDTH'(acc);
                exp_full = 1'b1;
            end else begin
                exp_overrun = 1'b1;
            end
        end else if (exp_full && rdy) begin
            exp_full = 1'b0;
        end
        exp_frame = done;
    endtask

    task automatic cycle(input bit r, input bit v, input bit b, input bit rdy);
        rst        = r;
        bit_valid  = v;
        bit_in     = b;
        word_ready = rdy;
        @(posedge clk);
        model_edge(r, v, b, rdy);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit rdy, input int gap);
        for (int i = 0; i < WIDTH; i++) begin
            cycle(1'b0, 1'b1, w[i], rdy);
            if (i != WIDTH - 1) repeat (gap) cycle(1'b0, 1'b0, 1'b0, rdy);
        end
    endtask

    // Monitor: outputs are stable at the falling edge; a handshake seen here
    // completes on the next rising edge unless reset overrides it.
    always @(negedge clk) begin
        if (started) begin
            check("word_valid", 32'(word_valid), 32'(exp_full));
            check("frame_done", 32'(frame_done), 32'(exp_frame));
            check("overrun", 32'(overrun), 32'(exp_overrun));
            check("word_out_hold", 32'(word_out), 32'(exp_last));
            if (word_valid && word_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(word_out), 32'hDEAD_BEEF);
                end else begin
                    check("handshake_word", 32'(word_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        started = 1'b1;
        check("reset_word_out", 32'(word_out), 32'h0);
        check("reset_valid", 32'(word_valid), 32'h0);

        // 0x5A, full rate, consumer always ready.
        send_word(8'h5A, 1'b1, 0);
        check("5a_word", 32'(word_out), 32'h5A);
        check("5a_valid", 32'(word_valid), 32'h1);
        check("5a_frame", 32'(frame_done), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("5a_frame_single", 32'(frame_done), 32'h0);
        check("5a_drained", 32'(word_valid), 32'h0);

        // Gapped bits complete only on the last valid bit.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH - 1; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0);
            repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
            check("gap_no_early_valid", 32'(word_valid), 32'h0);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("gap_word", 32'(word_out), 32'h7F);

        // Overrun: consumer stalled across two completions.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'hFF, 1'b0, 0);
        send_word(8'h01, 1'b0, 0);
        check("ovr_word_kept", 32'(word_out), 32'hFF);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_frame", 32'(frame_done), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_drained", 32'(word_valid), 32'h0);
        check("ovr_sticky", 32'(overrun), 32'h1);

        // Ready only on the edge the second word completes.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h3C, 1'b0, 0);
        for (int i = 0; i < WIDTH; i++) cycle(1'b0, 1'b1, 1'((8'hA5 >> i) & 1), i == WIDTH - 1);
        check("swap_valid", 32'(word_valid), 32'h1);
        check("swap_word", 32'(word_out), 32'hA5);
        check("swap_no_overrun", 32'(overrun), 32'h0);

        // Reset mid-word discards the partial bits.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("midrst_word", 32'(word_out), 32'h0);
        send_word(8'h0F, 1'b1, 0);
        check("midrst_clean", 32'(word_out), 32'h0F);

        // Reset on the completing edge wins.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH - 1; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("rstwin_valid", 32'(word_valid), 32'h0);
        check("rstwin_frame", 32'(frame_done), 32'h0);
        send_word(8'h81, 1'b1, 0);
        check("rstwin_cnt0", 32'(word_out), 32'h81);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7),
                  1'($urandom), 1'($urandom));
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_word_collector.md
# serial_word_collector

Downstream stage of the bit-serial two's-complement FSM. Collects the LSB-first serial result stream, one bit per valid cycle, into a parallel WIDTH-bit word. Presents the word on a valid/ready output with a one-word holding buffer. Emits a per-word framing pulse the parent uses to re-arm the upstream FSM.

## Interface

- WIDTH, 8, bits per word; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous active-high (one clock; reset is synchronous and active-high)
- bit_in  input  1  serial data bit from the upstream stage, LSB first
- bit_valid  input  1  bit_in is sampled on this edge when high
- word_out  output  WIDTH  assembled word; first received bit at bit 0
- word_valid  output  1  word_out holds an unconsumed word
- word_ready  input  1  consumer accepts word_out when high together with word_valid
- frame_done  output  1  one-cycle pulse: a word boundary was reached
- overrun  output  1  sticky: a completed word was dropped

## Operation

- Collector: shift register shreg[WIDTH-1:0] plus bit counter cnt (0..WIDTH-1).
  - Each edge with bit_valid=1: shreg <= {bit_in, shreg[WIDTH-1:1]}, cnt <= cnt+1.
  - bit_valid=0: shreg and cnt hold. Gaps of any length are legal.
  - On the edge sampling the WIDTH-th bit (cnt==WIDTH-1), the word completes as {bit_in, shreg[WIDTH-1:1]} and cnt wraps to 0.
- Output buffer state machine, states EMPTY (word_valid=0) and FULL (word_valid=1):
  - EMPTY + completion: load word_out, go to FULL.
  - FULL + word_ready, no completion: go to EMPTY. word_out holds its last value.
  - FULL + word_ready + completion on the same edge: load the new word, stay FULL, no overrun.
  - FULL + !word_ready + completion: drop the new word, keep word_out, set overrun.
  - word_ready while EMPTY has no effect.
- frame_done pulses on every completion, whether the word is loaded or dropped.
- overrun clears only on rst.
- Reset values: word_out=0, word_valid=0 (EMPTY), frame_done=0, overrun=0, cnt=0, shreg=0.
- rst mid-word discards the partial word. The first bit after rst is bit 0.
- rst wins over every simultaneous event.

## Timing

- All outputs are registered. No combinational path from input to output.
- Latency: word_valid and frame_done go high in the cycle after the edge that samples the last bit.
- Back-to-back words at full rate (bit_valid held high) complete every WIDTH cycles. With word_ready tied high there is no overrun.
- Handshake completes on an edge with word_valid=1 and word_ready=1.
  - word_valid falls in the next cycle unless a new word loads on that same edge.
- frame_done is high for exactly one cycle per word.
- The parent may drive the upstream FSM reset from frame_done. That reset lands on the edge after the completion, which is the first bit of the next word.

## Test plan

- WIDTH=8, word_ready=1, bits 0,1,0,1,1,0,1,0 on consecutive cycles -> word_valid=1 and word_out=8'h5A one cycle after the 8th edge; frame_done is a single pulse.
- WIDTH=3, bits 1,1,0 with bit_valid low for 2 cycles between each bit -> word_out=3'b011, completing on the 3rd valid bit only.
- WIDTH=8, word_ready=0, 0xFF streamed then 0x01 streamed -> word_out stays 8'hFF, overrun=1 after the second completion, frame_done pulses twice. word_ready=1 for one cycle -> word_valid=0, overrun still 1.
- WIDTH=8, continuous bits, word_ready asserted exactly on the edge the second word completes -> word_valid stays 1, word_out switches to the second word, overrun=0.
- WIDTH=8, rst=1 for one cycle after 5 bits of 0xFF -> all outputs 0. Then bits of 0x0F -> word_out=8'h0F, not a mix with the discarded bits.
- rst asserted on the same edge as a completing bit -> word_valid=0, frame_done=0, cnt=0 afterwards.
